funciones_sweep_ctrl: RTL and testbench

//   Sequencer for the a/b/c -> s1..s6 combinational logic-function block. On start it

---
 rtl/funciones_sweep_ctrl_if.sv | 27 ++
 rtl/funciones_sweep_ctrl.sv | 120 ++++++++++++
 tb/tb_funciones_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/funciones_sweep_ctrl_if.sv
// Bundle between the sweep sequencer, the test controller and the function block.
// Carries sweep control/status, the abc/s1..s6 pair and the truth-table read port.
// master = sequencer side, slave = controller/function-block side.
interface funciones_sweep_ctrl_if;
    logic       start;
    logic       step_mode;
    logic       step;
    logic [2:0] abc_o;
    logic [5:0] s_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] fail_mask;
    logic [2:0] first_fail;
    logic [2:0] rd_addr;
    logic [5:0] rd_data;

    modport master (
        input  start, step_mode, step, s_i, rd_addr,
        output abc_o, busy, done, pass, fail_mask, first_fail, rd_data
    );

    modport slave (
        output start, step_mode, step, s_i, rd_addr,
        input  abc_o, busy, done, pass, fail_mask, first_fail, rd_data
    );
endinterface

// File: rtl/funciones_sweep_ctrl.sv
// Sweeps {a,b,c} through 0..7, settles, captures s1..s6 and compares against a golden table.
// Latency: start in cycle T -> done in cycle T+1+8*(SETTLE_CYC+1); optional per-vector step pause.
// No backpressure: start is ignored unless idle, step only acts while paused after a sample.
module funciones_sweep_ctrl #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [47:0] EXPECTED   = 48'hDF689BC93DDC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    funciones_sweep_ctrl_if.master        bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTLE    = 3'd1;
    localparam logic [2:0] ST_SAMPLE    = 3'd2;
    localparam logic [2:0] ST_WAIT_STEP = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Terminal value of the settle counter (counter runs 0..SETTLE_CYC-1).
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    logic [2:0] state;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    logic       step_lat;
    logic [2:0] abc_q;
    logic       pass_q;
    logic [7:0] fail_mask_q;
    logic [2:0] first_fail_q;
    logic [5:0] table_q [8];
    logic [5:0] exp_entry;
    logic       mismatch;

    // Golden entry for the vector currently being sampled.
    always_comb begin
        exp_entry = EXPECTED[6*int'(idx) +: 6];
        mismatch  = (bus.s_i != exp_entry);
    end

    // Sweep FSM: sequencing, capture, comparison and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= 3'd0;
            settle_cnt   <= 4'd0;
            step_lat     <= 1'b0;
            abc_q        <= 3'd0;
            pass_q       <= 1'b0;
            fail_mask_q  <= 8'd0;
            first_fail_q <= 3'd0;
            for (int i = 0; i < 8; i++) table_q[i] <= 6'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        idx          <= 3'd0;
                        abc_q        <= 3'd0;
                        settle_cnt   <= 4'd0;
                        step_lat     <= bus.step_mode;
                        pass_q       <= 1'b0;
                        fail_mask_q  <= 8'd0;
                        first_fail_q <= 3'd0;
                        for (int i = 0; i < 8; i++) table_q[i] <= 6'd0;
                        state        <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    table_q[idx] <= bus.s_i;
                    if (mismatch) begin
                        fail_mask_q[idx] <= 1'b1;
                        // First mismatch of the sweep: mask is still empty.
                        if (fail_mask_q == 8'd0) first_fail_q <= idx;
                    end
                    if (idx == 3'd7) begin
                        // Drop abc back to 0 here so vector 7 is held no longer than the others.
                        abc_q <= 3'd0;
                        state <= ST_DONE;
                    end else if (step_lat) begin
                        state <= ST_WAIT_STEP;
                    end else begin
                        idx   <= idx + 3'd1;
                        abc_q <= idx + 3'd1;
                        state <= ST_SETTLE;
                    end
                end
                ST_WAIT_STEP: begin
                    if (bus.step) begin
                        idx   <= idx + 3'd1;
                        abc_q <= idx + 3'd1;
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    // fail_mask already includes the final sample's outcome.
                    pass_q <= (fail_mask_q == 8'd0);
                    abc_q  <= 3'd0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.abc_o      = abc_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.pass       = pass_q;
    assign bus.fail_mask  = fail_mask_q;
    assign bus.first_fail = first_fail_q;
    assign bus.rd_data    = table_q[bus.rd_addr];

endmodule

// File: tb/tb_funciones_sweep_ctrl.sv
// Randomized bench for the sweep sequencer with a truth-table function-block model.
// Stimulus pushes expected sweep results; a monitor pops and compares on every done pulse.
// A second instance with a 1-cycle settle checks the abc_o timing trace directly.
module tb_funciones_sweep_ctrl;

    localparam int S = 2;
    localparam logic [5:0] GOLD_TAB [8] = '{6'h1C, 6'h37, 6'h13, 6'h32,
                                            6'h1B, 6'h22, 6'h36, 6'h37};

    typedef struct packed {
        int              done_cyc;
        logic            pass;
        logic [7:0]      mask;
        logic [2:0]      ff;
        logic [7:0][5:0] tab;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   sweeps_done = 0;

    logic [5:0] corrupt [8];
    logic       use_stim;
    logic [2:0] stim_rd;
    logic [2:0] mon_rd;
    exp_t       exp_q [$];
    exp_t       mon_e;

    funciones_sweep_ctrl_if bus ();
    funciones_sweep_ctrl_if bus1 ();

    funciones_sweep_ctrl #(.SETTLE_CYC(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    funciones_sweep_ctrl #(.SETTLE_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function block models: golden truth table with optional per-entry corruption.
    assign bus.s_i      = GOLD_TAB[bus.abc_o] ^ corrupt[bus.abc_o];
    assign bus1.s_i     = GOLD_TAB[bus1.abc_o];
    assign bus.rd_addr  = use_stim ? stim_rd : mon_rd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference result of a sweep given the current corruption pattern.
    function automatic exp_t model(input int dc);
        exp_t e;
        e.done_cyc = dc;
        e.mask = 8'd0;
        e.ff   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            e.tab[i] = GOLD_TAB[i] ^ corrupt[i];
            if (corrupt[i] != 6'd0) e.mask[i] = 1'b1;
        end
        for (int i = 7; i >= 0; i--) if (e.mask[i]) e.ff = 3'(i);
        e.pass = (e.mask == 8'd0);
        return e;
    endfunction

    // Monitor: each done pulse pops one expected sweep and checks timing and results.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
                    @(negedge clk);
                    chk("busy_after_done", 64'(bus.busy), 64'd0);
                    chk("done_width", 64'(bus.done), 64'd0);
                    chk("pass", 64'(bus.pass), 64'(mon_e.pass));
                    chk("fail_mask", 64'(bus.fail_mask), 64'(mon_e.mask));
                    chk("first_fail", 64'(bus.first_fail), 64'(mon_e.ff));
                    for (int i = 0; i < 8; i++) begin
                        mon_rd = 3'(i);
                        #1;
                        chk("rd_data", 64'(bus.rd_data), 64'(mon_e.tab[i]));
                    end
                end
                sweeps_done++;
            end
        end
    end

    task automatic wait_result(input int nd);
        int n = 0;
        while (sweeps_done == nd && n < 120) begin
            @(negedge clk);
            n++;
        end
        if (sweeps_done == nd) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within %0d cycles, expected one", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic read_all_zero(input string nm);
        use_stim = 1'b1;
        for (int i = 0; i < 8; i++) begin
            stim_rd = 3'(i);
            #1;
            chk(nm, 64'(bus.rd_data), 64'd0);
        end
        use_stim = 1'b0;
    endtask

    task automatic run_sweep(input bit stepm, input bit extra);
        int  t, nd, dc, e;
        int  p [8];
        bit  spur;
        nd = sweeps_done;
        @(negedge clk);
        t = cyc;
        if (!stepm) begin
            dc = t + 1 + 8 * (S + 1);
        end else begin
            e = t;
            for (int k = 1; k < 8; k++) begin
                p[k] = e + S + 2 + int'($urandom_range(0, 4));
                e = p[k];
            end
            dc = p[7] + S + 2;
        end
        exp_q.push_back(model(dc));
        bus.step_mode = stepm;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        // step_mode must only matter at start.
        bus.step_mode = 1'($urandom);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        read_all_zero("table_cleared");
        if (!stepm) begin
            forever begin
                bus.start = extra && (cyc == t + 3 || cyc == dc - 1 || cyc == dc);
                if (cyc == dc) break;
                @(negedge clk);
            end
            @(negedge clk);
            bus.start = 1'b0;
        end else begin
            e = t;
            for (int k = 1; k < 8; k++) begin
                spur = 1'($urandom);
                forever begin
                    if (cyc >= e + S + 2) chk("abc_hold_wait", 64'(bus.abc_o), 64'(k - 1));
                    bus.step = (cyc == p[k]) || (spur && cyc == e + 1);
                    if (cyc == p[k]) break;
                    @(negedge clk);
                end
                e = p[k];
                @(negedge clk);
            end
            bus.step = 1'b0;
        end
        wait_result(nd);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0;
        bus1.start = 1'b0; bus1.step_mode = 1'b0; bus1.step = 1'b0; bus1.rd_addr = 3'd0;
        use_stim = 1'b0; stim_rd = 3'd0; mon_rd = 3'd0;
        for (int i = 0; i < 8; i++) corrupt[i] = 6'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_pass", 64'(bus.pass), 64'd0);
        chk("rst_fail_mask", 64'(bus.fail_mask), 64'd0);
        chk("rst_first_fail", 64'(bus.first_fail), 64'd0);
        chk("rst_abc", 64'(bus.abc_o), 64'd0);
        read_all_zero("rst_rd_data");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Golden block, then with stray start pulses during the sweep and in DONE.
        run_sweep(1'b0, 1'b0);
        run_sweep(1'b0, 1'b1);

        // s4 stuck-at-0.
        for (int i = 0; i < 8; i++) corrupt[i] = GOLD_TAB[i] & 6'h08;
        run_sweep(1'b0, 1'b0);

        // Golden block stepped.
        for (int i = 0; i < 8; i++) corrupt[i] = 6'd0;
        run_sweep(1'b1, 1'b0);

        // Random fault patterns and modes.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 8; i++)
                corrupt[i] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            run_sweep(1'($urandom), 1'($urandom));
        end

        // Reset mid-sweep: no done, everything cleared immediately.
        for (int i = 0; i < 8; i++) corrupt[i] = 6'd0;
        @(negedge clk);
        t = cyc;
        bus.step_mode = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < t + 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_abc", 64'(bus.abc_o), 64'd0);
        chk("midrst_fail_mask", 64'(bus.fail_mask), 64'd0);
        read_all_zero("midrst_rd_data");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        run_sweep(1'b0, 1'b0);

        // One-cycle settle instance: abc_o trace and done timing.
        @(negedge clk);
        t = cyc;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        while (cyc <= t + 16) begin
            chk("s1_abc_trace", 64'(bus1.abc_o), 64'((cyc - t - 1) / 2));
            chk("s1_no_early_done", 64'(bus1.done), 64'd0);
            @(negedge clk);
        end
        chk("s1_done_at_17", 64'(bus1.done), 64'd1);
        @(negedge clk);
        chk("s1_pass", 64'(bus1.pass), 64'd1);
        chk("s1_fail_mask", 64'(bus1.fail_mask), 64'd0);
        chk("s1_abc_idle", 64'(bus1.abc_o), 64'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
